dash_code_decoder: RTL and testbench

Receive end of the dashboard indicator link. It takes the 2-bit severity code produced by the dashboard indicator encoder and synchronises it, then glitch-filters it. It decodes the filtered code into registered lamp and buzzer drives: amber steady, amber slow blink, red fast blink plus buzzer, with an operator acknowledge that silences the buzzer. It sits between the encoder's code wires and the board LEDs/buzzer pin.

---
 rtl/dash_pkg.sv | 30 +++
 rtl/dash_code_filter.sv | 56 +++++
 rtl/dash_code_decoder.sv | 140 ++++++++++++++
 tb/tb_dash_code_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dash_pkg.sv
// Shared definitions for the dashboard indicator receive path.
//   - CODE_* : 2-bit severity codes as sent by the indicator encoder.
//   - dash_state_e : decoder state machine encoding.
//   - code_to_state : maps an accepted code to the state it selects.
package dash_pkg;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_WARN    = 2'b01;
  localparam logic [1:0] CODE_CAUTION = 2'b10;
  localparam logic [1:0] CODE_ALARM   = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WARN      = 3'd1,
    ST_CAUTION   = 3'd2,
    ST_ALARM     = 3'd3,
    ST_ALARM_ACK = 3'd4
  } dash_state_e;

  // A newly accepted alarm code always lands in ST_ALARM, never ST_ALARM_ACK.
  function automatic dash_state_e code_to_state(input logic [1:0] c);
    case (c)
      CODE_WARN:    return ST_WARN;
      CODE_CAUTION: return ST_CAUTION;
      CODE_ALARM:   return ST_ALARM;
      default:      return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dash_code_filter.sv
// Synchroniser and stability filter for the incoming severity code.
//   clk, rst_n   : clock, async active-low reset
//   code_in[1:0] : raw code, asynchronous to clk
//   status[1:0]  : last code seen unchanged for STABLE_CYCLES samples
//   code_change  : one-cycle pulse on the cycle status takes a new value
module dash_code_filter
  import dash_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code_in,
  output logic [1:0] status,
  output logic       code_change
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [1:0]    sync1, sync2;
  logic [1:0]    candidate;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= CODE_NONE;
      sync2       <= CODE_NONE;
      candidate   <= CODE_NONE;
      cnt         <= '0;
      status      <= CODE_NONE;
      code_change <= 1'b0;
    end else begin
      sync1 <= code_in;
      sync2 <= sync1;

      // Any disagreement restarts the stability count on the new value.
      if (sync2 != candidate) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      // The candidate has been stable long enough even if the sync stage
      // moves away on this same edge, so acceptance uses the old candidate.
      if ((cnt == CNT_MAX) && (candidate != status)) begin
        status      <= candidate;
        code_change <= 1'b1;
      end else begin
        code_change <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dash_code_decoder.sv
// Dashboard indicator receiver: filters the severity code and drives the
// amber/red lamps and buzzer, with an operator acknowledge for the buzzer.
//   clk, rst_n   : clock, async active-low reset
//   code[1:0]    : severity code from the encoder (async)
//   ack          : operator acknowledge level (async, pre-debounced)
//   lamp_amber   : amber lamp (steady for warn, slow blink for caution)
//   lamp_red     : red lamp (fast blink for alarm / acknowledged alarm)
//   buzzer       : audible alarm, silenced by acknowledge
//   status[1:0]  : currently accepted code
//   code_change  : one-cycle pulse when status changes
//   state_dbg    : current decoder state, for observation only
module dash_code_decoder
  import dash_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SLOW_DIV      = 50000000,
  parameter int FAST_DIV      = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  code,
  input  logic        ack,
  output logic        lamp_amber,
  output logic        lamp_red,
  output logic        buzzer,
  output logic [1:0]  status,
  output logic        code_change,
  output dash_state_e state_dbg
);

  localparam int SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam logic [SW-1:0] SLOW_MAX = SW'(SLOW_DIV - 1);
  localparam logic [FW-1:0] FAST_MAX = FW'(FAST_DIV - 1);

  dash_code_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .code_in     (code),
    .status      (status),
    .code_change (code_change)
  );

  logic        ack_s1, ack_s2, ack_prev;
  logic        ack_rise;
  dash_state_e state, state_nxt;
  logic [SW-1:0] slow_cnt, slow_cnt_nxt;
  logic [FW-1:0] fast_cnt, fast_cnt_nxt;
  logic        slow_ph, slow_ph_nxt;
  logic        fast_ph, fast_ph_nxt;
  logic        amber_d, red_d, buzzer_d;

  assign ack_rise  = ack_s2 & ~ack_prev;
  assign state_dbg = state;

  // Next state: a status change always wins over an acknowledge edge.
  always_comb begin
    state_nxt = state;
    if (code_change) begin
      state_nxt = code_to_state(status);
    end else if ((state == ST_ALARM) && ack_rise) begin
      state_nxt = ST_ALARM_ACK;
    end
  end

  // Blink generators restart with phase high on every state change so a
  // blinking lamp lights for a full half-period straight away.
  always_comb begin
    slow_cnt_nxt = slow_cnt;
    fast_cnt_nxt = fast_cnt;
    slow_ph_nxt  = slow_ph;
    fast_ph_nxt  = fast_ph;
    if (state_nxt != state) begin
      slow_cnt_nxt = '0;
      fast_cnt_nxt = '0;
      slow_ph_nxt  = 1'b1;
      fast_ph_nxt  = 1'b1;
    end else begin
      if (slow_cnt == SLOW_MAX) begin
        slow_cnt_nxt = '0;
        slow_ph_nxt  = ~slow_ph;
      end else begin
        slow_cnt_nxt = slow_cnt + 1'b1;
      end
      if (fast_cnt == FAST_MAX) begin
        fast_cnt_nxt = '0;
        fast_ph_nxt  = ~fast_ph;
      end else begin
        fast_cnt_nxt = fast_cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next-cycle values so the registered lamps
  // line up with the state register rather than trailing it by a cycle.
  always_comb begin
    amber_d  = 1'b0;
    red_d    = 1'b0;
    buzzer_d = 1'b0;
    case (state_nxt)
      ST_WARN:      amber_d = 1'b1;
      ST_CAUTION:   amber_d = slow_ph_nxt;
      ST_ALARM: begin
        red_d    = fast_ph_nxt;
        buzzer_d = 1'b1;
      end
      ST_ALARM_ACK: red_d = fast_ph_nxt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1     <= 1'b0;
      ack_s2     <= 1'b0;
      ack_prev   <= 1'b0;
      state      <= ST_OFF;
      slow_cnt   <= '0;
      fast_cnt   <= '0;
      slow_ph    <= 1'b0;
      fast_ph    <= 1'b0;
      lamp_amber <= 1'b0;
      lamp_red   <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      ack_s1     <= ack;
      ack_s2     <= ack_s1;
      ack_prev   <= ack_s2;
      state      <= state_nxt;
      slow_cnt   <= slow_cnt_nxt;
      fast_cnt   <= fast_cnt_nxt;
      slow_ph    <= slow_ph_nxt;
      fast_ph    <= fast_ph_nxt;
      lamp_amber <= amber_d;
      lamp_red   <= red_d;
      buzzer     <= buzzer_d;
    end
  end

endmodule

// File: tb/tb_dash_code_decoder.sv
module tb_dash_code_decoder;
  import dash_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  code;
  logic        ack;
  logic        lamp_amber;
  logic        lamp_red;
  logic        buzzer;
  logic [1:0]  status;
  logic        code_change;
  dash_state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  dash_code_decoder #(
    .STABLE_CYCLES (4),
    .SLOW_DIV      (8),
    .FAST_DIV      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code        (code),
    .ack         (ack),
    .lamp_amber  (lamp_amber),
    .lamp_red    (lamp_red),
    .buzzer      (buzzer),
    .status      (status),
    .code_change (code_change),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    code  = CODE_NONE;
    ack   = 1'b0;
    #1;
    n_cmp++;
    if ({lamp_amber, lamp_red, buzzer, status, code_change} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_hold: outs=%b want 000000",
               {lamp_amber, lamp_red, buzzer, status, code_change});
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++;
      if ({lamp_amber, lamp_red, buzzer, status, code_change} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: outs=%b want 000000", i,
                 {lamp_amber, lamp_red, buzzer, status, code_change});
      end
    end
    n_cmp++;
    if (state_dbg !== ST_OFF) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_OFF);
    end
  endtask

  task automatic test_warn();
    code = CODE_WARN;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i < 7) begin
        n_cmp++;
        if ({status, code_change, lamp_amber} !== {2'b00, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL warn_wait cyc%0d: st=%b cc=%b amb=%b want 00/0/0",
                   i, status, code_change, lamp_amber);
        end
      end else if (i == 7) begin
        n_cmp++;
        if ({status, code_change, lamp_amber} !== {2'b01, 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL warn_accept: st=%b cc=%b amb=%b want 01/1/0",
                   status, code_change, lamp_amber);
        end
      end else begin
        n_cmp++;
        if ({status, code_change, lamp_amber, lamp_red, buzzer} !==
            {2'b01, 1'b0, 1'b1, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL warn_lamp cyc%0d: st=%b cc=%b a=%b r=%b b=%b want 01/0/1/0/0",
                   i, status, code_change, lamp_amber, lamp_red, buzzer);
        end
      end
    end
  endtask

  task automatic test_caution();
    logic exp_amb;
    code = CODE_CAUTION;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 7) begin
        n_cmp++;
        if ({status, code_change} !== {2'b10, 1'b1}) begin
          n_err++;
          $display("FAIL caution_accept: st=%b cc=%b want 10/1", status, code_change);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (state_dbg !== ST_CAUTION) begin
          n_err++;
          $display("FAIL caution_state: got %0d want %0d", state_dbg, ST_CAUTION);
        end
      end
      if (i >= 8) begin
        exp_amb = (((i - 8) / 8) % 2) == 0;
        n_cmp++;
        if ({lamp_amber, lamp_red, buzzer} !== {exp_amb, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL caution_blink cyc%0d: a=%b r=%b b=%b want %b/0/0",
                   i, lamp_amber, lamp_red, buzzer, exp_amb);
        end
      end
    end
  endtask

  task automatic test_alarm_ack();
    logic exp_red;
    code = CODE_ALARM;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 7) begin
        n_cmp++;
        if (buzzer !== 1'b0) begin
          n_err++;
          $display("FAIL alarm_early: buzzer=%b want 0", buzzer);
        end
      end
      if (i >= 8) begin
        exp_red = (((i - 8) / 2) % 2) == 0;
        n_cmp++;
        if ({lamp_amber, lamp_red, buzzer} !== {1'b0, exp_red, 1'b1}) begin
          n_err++;
          $display("FAIL alarm_blink cyc%0d: a=%b r=%b b=%b want 0/%b/1",
                   i, lamp_amber, lamp_red, buzzer, exp_red);
        end
      end
    end
    // 3-cycle acknowledge pulse
    ack = 1'b1;
    step();
    step();
    n_cmp++;
    if (buzzer !== 1'b1) begin
      n_err++;
      $display("FAIL ack_early: buzzer=%b want 1", buzzer);
    end
    step();
    ack = 1'b0;
    n_cmp++;
    if ({buzzer, lamp_red, state_dbg} !== {1'b0, 1'b1, ST_ALARM_ACK}) begin
      n_err++;
      $display("FAIL ack_silence: b=%b r=%b st=%0d want 0/1/%0d",
               buzzer, lamp_red, state_dbg, ST_ALARM_ACK);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_red = ((i / 2) % 2) == 0;
      n_cmp++;
      if ({buzzer, lamp_red} !== {1'b0, exp_red}) begin
        n_err++;
        $display("FAIL ack_blink cyc%0d: b=%b r=%b want 0/%b", i, buzzer, lamp_red, exp_red);
      end
    end
    // 11 -> 10 -> 11 re-arms the buzzer
    code = CODE_CAUTION;
    repeat (8) step();
    n_cmp++;
    if ({lamp_amber, lamp_red, buzzer, state_dbg} !== {1'b1, 1'b0, 1'b0, ST_CAUTION}) begin
      n_err++;
      $display("FAIL rearm_caution: a=%b r=%b b=%b st=%0d want 1/0/0/%0d",
               lamp_amber, lamp_red, buzzer, state_dbg, ST_CAUTION);
    end
    code = CODE_ALARM;
    repeat (8) step();
    n_cmp++;
    if ({buzzer, lamp_red, state_dbg} !== {1'b1, 1'b1, ST_ALARM}) begin
      n_err++;
      $display("FAIL rearm_alarm: b=%b r=%b st=%0d want 1/1/%0d",
               buzzer, lamp_red, state_dbg, ST_ALARM);
    end
  endtask

  task automatic test_glitch();
    code = CODE_WARN;
    repeat (8) step();
    n_cmp++;
    if ({status, lamp_amber, buzzer, state_dbg} !== {2'b01, 1'b1, 1'b0, ST_WARN}) begin
      n_err++;
      $display("FAIL glitch_setup: st=%b a=%b b=%b fsm=%0d want 01/1/0/%0d",
               status, lamp_amber, buzzer, state_dbg, ST_WARN);
    end
    // acknowledge outside ALARM is ignored
    ack = 1'b1;
    repeat (3) step();
    ack = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({state_dbg, lamp_amber} !== {ST_WARN, 1'b1}) begin
      n_err++;
      $display("FAIL ack_ignored: fsm=%0d a=%b want %0d/1", state_dbg, lamp_amber, ST_WARN);
    end
    // 3-cycle glitch to alarm
    code = CODE_ALARM;
    repeat (3) step();
    code = CODE_WARN;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if ({status, code_change, buzzer} !== {2'b01, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL glitch_reject cyc%0d: st=%b cc=%b b=%b want 01/0/0",
                 i, status, code_change, buzzer);
      end
    end
    // a held alarm is accepted
    code = CODE_ALARM;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        n_cmp++;
        if ({status, code_change} !== {2'b11, 1'b1}) begin
          n_err++;
          $display("FAIL hold_accept: st=%b cc=%b want 11/1", status, code_change);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if ({buzzer, code_change} !== {1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL hold_buzzer: b=%b cc=%b want 1/0", buzzer, code_change);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lamp_amber, lamp_red, buzzer, status, code_change, state_dbg} !==
        {6'b0, ST_OFF}) begin
      n_err++;
      $display("FAIL reset_async: outs=%b fsm=%0d want 000000/%0d",
               {lamp_amber, lamp_red, buzzer, status, code_change}, state_dbg, ST_OFF);
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) begin
        n_cmp++;
        if (buzzer !== 1'b0) begin
          n_err++;
          $display("FAIL rerelease_early cyc%0d: buzzer=%b want 0", i, buzzer);
        end
      end else begin
        n_cmp++;
        if ({buzzer, status} !== {1'b1, 2'b11}) begin
          n_err++;
          $display("FAIL rerelease_buzzer: b=%b st=%b want 1/11", buzzer, status);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_warn();
    test_caution();
    test_alarm_ack();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
